regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between NUM_SRC writeback sources (slot 0 ALU, slot 1 load unit, slot 2 multi-cycle mul/div).
- Round-robin arbitration over valid/ready handshakes; the winning write is registered onto reg_wr_en/rWA/rWData.
- Keeps a per-register pending-write scoreboard (busy bits) that decode uses for RAW hazard stalls.
- Sits between the execute/memory writeback paths and the register file write port.

Parameters:
- NUM_SRC, 3, number of writeback requesters (2..4)
- XLEN, 32, data width
- AW, 5, register address width (2**AW registers)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_SRC  per-source write request
- req_ready  out  NUM_SRC  per-source grant; transfer occurs when valid&ready
- req_addr  in  NUM_SRC*AW  packed destination addresses; source i uses bits [i*AW +: AW]
- req_data  in  NUM_SRC*XLEN  packed write data; source i uses bits [i*XLEN +: XLEN]
- issue_valid  in  1  decode issued an instruction with a destination register
- issue_rd  in  AW  destination register of the issued instruction
- flush  in  1  pipeline flush; clears the scoreboard
- busy  out  2**AW  bit r=1 means a write to register r is pending
- reg_wr_en  out  1  register file write enable
- rWA  out  AW  register file write address
- rWData  out  XLEN  register file write data
- grant_id  out  2  source index of the last accepted write (debug)

Behaviour:
- Reset values (async): reg_wr_en=0, rWA=0, rWData=0, grant_id=0, busy=all 0, rr_ptr=0.
- Arbitration is combinational in the request cycle:
  - Search starts at rr_ptr and wraps modulo NUM_SRC; the first source with req_valid=1 wins.
  - At most one req_ready bit is high, and only for that winner.
  - req_ready never asserts for a source whose req_valid=0.
  - No valid requests: all req_ready=0, rr_ptr holds.
- On acceptance from source k:
  - rr_ptr <= (k+1) mod NUM_SRC.
  - Next edge: reg_wr_en=1, rWA=req_addr[k], rWData=req_data[k], grant_id=k.
  - Latency is exactly 1 cycle from handshake to write port. Throughput is 1 write/cycle.
- Cycles with no acceptance: reg_wr_en=0 at the next edge; rWA, rWData and grant_id hold.
- Sources must hold valid, addr and data stable until ready. Losing sources keep waiting, and round-robin guarantees a grant within NUM_SRC cycles.
- Address x0:
  - A request to x0 is accepted (ready asserted, rr_ptr advances) but produces reg_wr_en=0.
  - issue_rd=0 never sets busy[0]; busy[0] is always 0.
- Scoreboard, updated at each clock edge:
  - set: issue_valid && issue_rd!=0 sets busy[issue_rd].
  - clear: an accepted request clears busy[addr] in the same edge the write is registered.
  - Set and clear of the same register in the same cycle: set wins, because the issue is younger.
  - Set and clear of different registers both apply.
  - flush=1: busy <= all 0 and takes priority over set and clear. Arbitration and the write port are unaffected by flush; in-flight requests still complete.
- busy is the registered value, with no combinational bypass from the current cycle's clear.
- Clearing a register whose busy bit is already 0 is legal and has no effect.
- Reset mid-operation:
  - Outputs go to reset values immediately and any registered write is dropped (reg_wr_en=0).
  - Pending requests are re-arbitrated from rr_ptr=0 after rst deasserts.

Test Plan:
- Single source: src0 valid, addr=5, data=0xDEADBEEF -> req_ready[0]=1 in that cycle; next cycle reg_wr_en=1, rWA=5, rWData=0xDEADBEEF, grant_id=0.
- Contention: all three sources valid continuously (addr 1/2/3) from reset -> grants go 0,1,2,0 on consecutive cycles; rWA sequence 1,2,3,1; exactly one ready per cycle.
- x0 write: src1 valid, addr=0, data=0xFFFFFFFF -> req_ready[1]=1, reg_wr_en stays 0, and the next grant goes to src2 when it is valid.
- Scoreboard:
  - issue_rd=7 -> busy[7]=1 next cycle.
  - src2 writes addr=7 -> busy[7]=0 after that edge.
  - Same-cycle issue_rd=9 and accepted write to 9 -> busy[9]=1.
- Flush and issue_rd=0: issue rd 4 and 6, then flush=1 -> busy=0 next cycle; issue_rd=0 -> busy[0] stays 0.
- Async reset mid-stream: assert rst between clock edges while reg_wr_en=1 -> reg_wr_en=0 and busy=0 without waiting for a clock edge; after release with src1 and src2 valid, src1 is granted first.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port, with a per-register
// pending-write scoreboard that decode uses for RAW hazard stalls.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned AW      = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SRC-1:0]      req_valid,
    output logic [NUM_SRC-1:0]      req_ready,
    input  logic [NUM_SRC*AW-1:0]   req_addr,
    input  logic [NUM_SRC*XLEN-1:0] req_data,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_rd,
    input  logic                    flush,
    output logic [(2**AW)-1:0]      busy,
    output logic                    reg_wr_en,
    output logic [AW-1:0]           rWA,
    output logic [XLEN-1:0]         rWData,
    output logic [1:0]              grant_id
);

    localparam int unsigned NREG = 2 ** AW;

    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [3:0]      valid_pad;
    logic [3:0]      ready_pad;
    logic [1:0]      cand;
    logic [1:0]      win;
    logic            found;
    logic [AW-1:0]   win_addr;
    logic [XLEN-1:0] win_data;

    // Padding to four slots keeps the 2-bit slot index in range for any NUM_SRC.
    always_comb begin
        valid_pad = 4'(req_valid);
        found     = 1'b0;
        win       = 2'd0;
        cand      = 2'd0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cand = 2'((32'(rr_ptr_q) + i) % NUM_SRC);
            if (!found && valid_pad[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        ready_pad = '0;
        if (found) begin
            ready_pad[win] = 1'b1;
        end
        req_ready = ready_pad[NUM_SRC-1:0];
    end

    assign win_addr = req_addr[32'(win)*AW +: AW];
    assign win_data = req_data[32'(win)*XLEN +: XLEN];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (found) begin
            rr_ptr_d = (32'(win) + 1 == NUM_SRC) ? 2'd0 : win + 2'd1;
        end
    end

    // The issue is younger than the retiring write, so its set overrides the clear.
    always_comb begin
        busy_d = busy_q;
        if (found) begin
            busy_d[win_addr] = 1'b0;
        end
        if (issue_valid && issue_rd != '0) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q  <= 2'd0;
            busy_q    <= '0;
            reg_wr_en <= 1'b0;
            rWA       <= '0;
            rWData    <= '0;
            grant_id  <= 2'd0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            busy_q    <= busy_d;
            // Writes to x0 are accepted but never reach the register file.
            reg_wr_en <= found && (win_addr != '0);
            if (found) begin
                rWA      <= win_addr;
                rWData   <= win_data;
                grant_id <= win;
            end
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed vector table, hand-written scoreboard/reset
// sequences, and randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    req_valid = '0;
    logic [2:0]    req_ready;
    logic [14:0]   req_addr = '0;
    logic [95:0]   req_data = '0;
    logic          issue_valid = 1'b0;
    logic [4:0]    issue_rd = '0;
    logic          flush = 1'b0;
    logic [31:0]   busy;
    logic          reg_wr_en;
    logic [4:0]    rWA;
    logic [31:0]   rWData;
    logic [1:0]    grant_id;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NUM_SRC(3), .XLEN(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .flush(flush), .busy(busy), .reg_wr_en(reg_wr_en),
        .rWA(rWA), .rWData(rWData), .grant_id(grant_id)
    );

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] addr;
        logic [95:0] data;
        logic [2:0]  exp_ready;
        logic        exp_wr;
        logic [4:0]  exp_wa;
        logic [31:0] exp_wd;
        logic [1:0]  exp_gid;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                          input logic iv, input logic [4:0] rd, input logic fl);
        req_valid   = v;
        req_addr    = a;
        req_data    = d;
        issue_valid = iv;
        issue_rd    = rd;
        flush       = fl;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(3'b000, '0, '0, 1'b0, 5'd0, 1'b0);
        rst = 1'b1;
        #7;
        rst = 1'b0;
        after_edge();
    endtask

    // Behavioural model state
    int          m_ptr;
    logic [31:0] m_busy;
    logic        m_wr;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic [1:0]  m_gid;

    function automatic int model_winner(input logic [2:0] v);
        int w = -1;
        for (int k = 0; k < N; k++) begin
            int s = (m_ptr + k) % N;
            if (w < 0 && v[s]) w = s;
        end
        return w;
    endfunction

    task automatic model_edge(input int w);
        logic [31:0] nb = m_busy;
        if (w >= 0) begin
            logic [4:0] a = req_addr[w*5 +: 5];
            m_wr  = (a != 0);
            m_wa  = a;
            m_wd  = req_data[w*32 +: 32];
            m_gid = 2'(w);
            m_ptr = (w + 1) % N;
            nb[a] = 1'b0;
        end else begin
            m_wr = 1'b0;
        end
        if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
        if (flush) nb = '0;
        m_busy = nb;
    endtask

    logic [2:0]  cur_v;
    logic [14:0] cur_a;
    logic [95:0] cur_d;

    initial begin
        // Contention from reset, single source, x0 write, hold-while-losing, idle
        vecs[0] = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'h33333333, 32'h22222222, 32'h11111111},
                    3'b001, 1'b1, 5'd1, 32'h11111111, 2'd0};
        vecs[1] = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'h33333333, 32'h22222222, 32'h11111111},
                    3'b010, 1'b1, 5'd2, 32'h22222222, 2'd1};
        vecs[2] = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'h33333333, 32'h22222222, 32'h11111111},
                    3'b100, 1'b1, 5'd3, 32'h33333333, 2'd2};
        vecs[3] = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'h33333333, 32'h22222222, 32'h11111111},
                    3'b001, 1'b1, 5'd1, 32'h11111111, 2'd0};
        vecs[4] = '{3'b001, {5'd0, 5'd0, 5'd5}, {64'h0, 32'hDEADBEEF},
                    3'b001, 1'b1, 5'd5, 32'hDEADBEEF, 2'd0};
        vecs[5] = '{3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'hFFFFFFFF, 32'h0},
                    3'b010, 1'b0, 5'd0, 32'h0, 2'd1};
        vecs[6] = '{3'b101, {5'd10, 5'd0, 5'd8}, {32'hA0A0A0A0, 32'h0, 32'h80808080},
                    3'b100, 1'b1, 5'd10, 32'hA0A0A0A0, 2'd2};
        vecs[7] = '{3'b001, {5'd10, 5'd0, 5'd8}, {32'hA0A0A0A0, 32'h0, 32'h80808080},
                    3'b001, 1'b1, 5'd8, 32'h80808080, 2'd0};
        vecs[8] = '{3'b000, {5'd0, 5'd0, 5'd0}, 96'h0,
                    3'b000, 1'b0, 5'd8, 32'h80808080, 2'd0};

        #2;
        chk("reset_wr_en", 64'(reg_wr_en), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rwa", 64'(rWA), 64'd0);
        chk("reset_rwdata", 64'(rWData), 64'd0);
        chk("reset_gid", 64'(grant_id), 64'd0);
        do_reset();

        for (int i = 0; i < 9; i++) begin
            set_in(vecs[i].valid, vecs[i].addr, vecs[i].data, 1'b0, 5'd0, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
            after_edge();
            chk($sformatf("vec%0d_wr_en", i), 64'(reg_wr_en), 64'(vecs[i].exp_wr));
            chk($sformatf("vec%0d_gid", i), 64'(grant_id), 64'(vecs[i].exp_gid));
            if (vecs[i].exp_wr) begin
                chk($sformatf("vec%0d_rwa", i), 64'(rWA), 64'(vecs[i].exp_wa));
                chk($sformatf("vec%0d_rwdata", i), 64'(rWData), 64'(vecs[i].exp_wd));
            end
        end

        // Scoreboard set, clear, same-cycle set-wins, flush priority
        do_reset();
        set_in(3'b000, '0, '0, 1'b1, 5'd7, 1'b0);
        after_edge();
        chk("sb_set7", 64'(busy), 64'h80);
        set_in(3'b100, {5'd7, 10'd0}, {32'h77777777, 64'h0}, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("sb_ready_src2", 64'(req_ready), 64'b100);
        after_edge();
        chk("sb_clear7", 64'(busy), 64'h0);
        chk("sb_wr7", 64'({reg_wr_en, rWA, grant_id}), 64'({1'b1, 5'd7, 2'd2}));
        set_in(3'b001, {10'd0, 5'd9}, {64'h0, 32'h99999999}, 1'b1, 5'd9, 1'b0);
        after_edge();
        chk("sb_setwins9", 64'(busy), 64'h200);
        set_in(3'b000, '0, '0, 1'b1, 5'd4, 1'b0);
        after_edge();
        set_in(3'b000, '0, '0, 1'b1, 5'd6, 1'b0);
        after_edge();
        chk("sb_multi", 64'(busy), 64'h250);
        set_in(3'b010, {5'd0, 5'd3, 5'd0}, {32'h0, 32'h33330000, 32'h0}, 1'b1, 5'd11, 1'b1);
        @(negedge clk);
        chk("flush_ready", 64'(req_ready), 64'b010);
        after_edge();
        chk("flush_busy", 64'(busy), 64'h0);
        chk("flush_write", 64'({reg_wr_en, rWA}), 64'({1'b1, 5'd3}));
        set_in(3'b000, '0, '0, 1'b1, 5'd0, 1'b0);
        after_edge();
        chk("rd0_busy", 64'(busy), 64'h0);

        // Async reset between edges while a write is on the port
        set_in(3'b001, {10'd0, 5'd12}, {64'h0, 32'hABCD}, 1'b1, 5'd12, 1'b0);
        after_edge();
        chk("pre_rst_wr", 64'({reg_wr_en, rWA}), 64'({1'b1, 5'd12}));
        chk("pre_rst_busy", 64'(busy), 64'h1000);
        set_in(3'b000, '0, '0, 1'b0, 5'd0, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_wr", 64'(reg_wr_en), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_gid", 64'(grant_id), 64'd0);
        rst = 1'b0;
        set_in(3'b110, {5'd2, 5'd1, 5'd0}, {32'h2, 32'h1, 32'h0}, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("post_rst_ready", 64'(req_ready), 64'b010);
        after_edge();
        chk("post_rst_gid", 64'({reg_wr_en, rWA, grant_id}), 64'({1'b1, 5'd1, 2'd1}));

        // Randomized traffic against the model
        do_reset();
        m_ptr = 0; m_busy = '0; m_wr = 1'b0; m_wa = '0; m_wd = '0; m_gid = '0;
        cur_v = '0; cur_a = '0; cur_d = '0;
        for (int c = 0; c < 400; c++) begin
            int w;
            for (int s = 0; s < N; s++) begin
                if (!cur_v[s]) begin
                    cur_v[s] = ($urandom_range(0, 2) != 0);
                    cur_a[s*5 +: 5] = 5'($urandom_range(0, 31));
                    cur_d[s*32 +: 32] = $urandom;
                end
            end
            set_in(cur_v, cur_a, cur_d, 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), ($urandom_range(0, 19) == 0));
            @(negedge clk);
            w = model_winner(cur_v);
            chk("rnd_ready", 64'(req_ready), (w >= 0) ? 64'(1 << w) : 64'd0);
            after_edge();
            model_edge(w);
            if (w >= 0) cur_v[w] = 1'b0;
            chk("rnd_wr_en", 64'(reg_wr_en), 64'(m_wr));
            chk("rnd_gid", 64'(grant_id), 64'(m_gid));
            chk("rnd_busy", 64'(busy), 64'(m_busy));
            if (m_wr) chk("rnd_write", 64'({rWA, rWData}), 64'({m_wa, m_wd}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
